// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the pipeline hazard/stall control unit.
package hazard_stall_unit_pkg;

  localparam logic [3:0]  REG_PC = 4'd15;
  localparam int unsigned REG_W  = $bits(REG_PC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic rn_exe;
    logic rn_mem;
    logic rm_exe;
    logic rm_mem;
  } fwd_sel_t;

  // A source operand depends on a producer that writes the same register.
  function automatic logic reg_match(input logic             i_src_en,
                                     input logic             i_wb_en,
                                     input logic [REG_W-1:0] i_dest,
                                     input logic [REG_W-1:0] i_src);
    return i_src_en & i_wb_en & (i_dest == i_src);
  endfunction

endpackage

// File: rtl/hazard_stall_unit_fwd_select.sv
// RAW match detection, hazard decision and forwarding-select generation for ID.
module hazard_stall_unit_fwd_select
  import hazard_stall_unit_pkg::*;
(
  input  logic [REG_W-1:0] i_rn,
  input  logic [REG_W-1:0] i_rm,
  input  logic             i_use_rn,
  input  logic             i_two_src,
  input  logic             i_fwd_en,
  input  logic [REG_W-1:0] i_exe_dest,
  input  logic             i_exe_wb_en,
  input  logic             i_exe_mem_r_en,
  input  logic [REG_W-1:0] i_mem_dest,
  input  logic             i_mem_wb_en,
  output logic             o_hz,
  output fwd_sel_t         o_sel
);

  logic w_rn_e;
  logic w_rn_m;
  logic w_rm_e;
  logic w_rm_m;

  assign w_rn_e = reg_match(i_use_rn,  i_exe_wb_en, i_exe_dest, i_rn);
  assign w_rn_m = reg_match(i_use_rn,  i_mem_wb_en, i_mem_dest, i_rn);
  assign w_rm_e = reg_match(i_two_src, i_exe_wb_en, i_exe_dest, i_rm);
  assign w_rm_m = reg_match(i_two_src, i_mem_wb_en, i_mem_dest, i_rm);

  // Without forwarding any pending writer stalls; with it only load-use does.
  always_comb begin
    o_hz  = 1'b0;
    o_sel = '0;
    if (i_fwd_en) begin
      o_hz = i_exe_mem_r_en & (w_rn_e | w_rm_e);
      if (!o_hz) begin
        o_sel.rn_exe = w_rn_e & ~i_exe_mem_r_en;
        o_sel.rn_mem = w_rn_m & ~w_rn_e;
        o_sel.rm_exe = w_rm_e & ~i_exe_mem_r_en;
        o_sel.rm_mem = w_rm_m & ~w_rm_e;
      end
    end else begin
      o_hz = w_rn_e | w_rn_m | w_rm_e | w_rm_m;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline control: SRAM wait-state FSM plus freeze/flush/forwarding outputs
// for the IF/ID and ID/EX stage registers.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int unsigned SRAM_WAIT = 3,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] Rn,
  input  logic [REG_W-1:0] Rm,
  input  logic             use_Rn,
  input  logic             two_src,
  input  logic             fwd_en,
  input  logic [REG_W-1:0] EXE_Dest,
  input  logic             EXE_WB_EN,
  input  logic             EXE_MEM_R_EN,
  input  logic [REG_W-1:0] MEM_Dest,
  input  logic             MEM_WB_EN,
  input  logic             B_taken,
  input  logic             mem_req,
  output logic             freeze_front,
  output logic             freeze_back,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             fRnSEXE,
  output logic             fRnSMEM,
  output logic             fRmSEXE,
  output logic             fRmSMEM,
  output logic             mem_done
);

  localparam bit              HAS_WAIT = (SRAM_WAIT != 0);
  localparam bit              ONE_WAIT = (SRAM_WAIT == 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SRAM_WAIT - 1);

  mem_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;

  logic     w_hz;
  fwd_sel_t w_sel;
  logic     w_req_start;
  logic     w_mem_stall;
  logic     w_mem_done;

  hazard_stall_unit_fwd_select u_fwd_select (
    .i_rn           (Rn),
    .i_rm           (Rm),
    .i_use_rn       (use_Rn),
    .i_two_src      (two_src),
    .i_fwd_en       (fwd_en),
    .i_exe_dest     (EXE_Dest),
    .i_exe_wb_en    (EXE_WB_EN),
    .i_exe_mem_r_en (EXE_MEM_R_EN),
    .i_mem_dest     (MEM_Dest),
    .i_mem_wb_en    (MEM_WB_EN),
    .o_hz           (w_hz),
    .o_sel          (w_sel)
  );

  assign w_req_start = mem_req & HAS_WAIT;

  // r_cnt holds the stall cycles still owed, counting the current WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_start) begin
            if (ONE_WAIT) begin
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt <= CNT_W'(1)) begin
            r_state <= ST_DONE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // The first access cycle stalls before the FSM has left IDLE.
  assign w_mem_stall = (r_state == ST_WAIT) | ((r_state == ST_IDLE) & w_req_start);
  assign w_mem_done  = HAS_WAIT ? (r_state == ST_DONE) : mem_req;

  always_comb begin
    freeze_front = 1'b0;
    freeze_back  = 1'b0;
    flush_ifid   = 1'b0;
    flush_idex   = 1'b0;
    fRnSEXE      = 1'b0;
    fRnSMEM      = 1'b0;
    fRmSEXE      = 1'b0;
    fRmSMEM      = 1'b0;
    mem_done     = 1'b0;
    if (!rst) begin
      freeze_back  = w_mem_stall;
      freeze_front = w_mem_stall | w_hz;
      flush_idex   = ~w_mem_stall & (w_hz | B_taken);
      flush_ifid   = ~w_mem_stall & B_taken;
      fRnSEXE      = w_sel.rn_exe;
      fRnSMEM      = w_sel.rn_mem;
      fRmSEXE      = w_sel.rm_exe;
      fRmSMEM      = w_sel.rm_mem;
      mem_done     = w_mem_done;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed scenarios then random traffic.
module tb_hazard_stall_unit;

  localparam int unsigned SRAM_WAIT = 3;
  localparam int unsigned CNT_W     = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] Rn, Rm, EXE_Dest, MEM_Dest;
  logic       use_Rn, two_src, fwd_en, EXE_WB_EN, EXE_MEM_R_EN, MEM_WB_EN;
  logic       B_taken, mem_req;
  logic       freeze_front, freeze_back, flush_ifid, flush_idex;
  logic       fRnSEXE, fRnSMEM, fRmSEXE, fRmSMEM, mem_done;

  always #5 clk = ~clk;

  hazard_stall_unit #(.SRAM_WAIT(SRAM_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .Rn(Rn), .Rm(Rm), .use_Rn(use_Rn), .two_src(two_src),
    .fwd_en(fwd_en), .EXE_Dest(EXE_Dest), .EXE_WB_EN(EXE_WB_EN),
    .EXE_MEM_R_EN(EXE_MEM_R_EN), .MEM_Dest(MEM_Dest), .MEM_WB_EN(MEM_WB_EN),
    .B_taken(B_taken), .mem_req(mem_req), .freeze_front(freeze_front),
    .freeze_back(freeze_back), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .fRnSEXE(fRnSEXE), .fRnSMEM(fRnSMEM), .fRmSEXE(fRmSEXE), .fRmSMEM(fRmSMEM),
    .mem_done(mem_done)
  );

  typedef struct {
    logic       rst;
    logic [3:0] rn, rm, exe_dest, mem_dest;
    logic       use_rn, two_src, fwd_en, exe_wb, exe_ld, mem_wb, b_taken, mem_req;
  } stim_t;

  // v = {freeze_front, freeze_back, flush_ifid, flush_idex,
  //      fRnSEXE, fRnSMEM, fRmSEXE, fRmSMEM, mem_done}
  typedef struct {
    logic [8:0] v;
    int         cyc;
  } exp_t;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_err    = 0;
  int    cyc      = 0;
  int    acc_age  = 0;   // cycles the current SRAM access has been in progress
  string names[9] = '{"mem_done", "fRmSMEM", "fRmSEXE", "fRnSMEM", "fRnSEXE",
                      "flush_idex", "flush_ifid", "freeze_back", "freeze_front"};

  function automatic stim_t idle_stim();
    stim_t s;
    s.rst = 1'b0; s.rn = '0; s.rm = '0; s.exe_dest = '0; s.mem_dest = '0;
    s.use_rn = 1'b0; s.two_src = 1'b0; s.fwd_en = 1'b1; s.exe_wb = 1'b0;
    s.exe_ld = 1'b0; s.mem_wb = 1'b0; s.b_taken = 1'b0; s.mem_req = 1'b0;
    return s;
  endfunction

  // Apply one cycle of stimulus and queue the response the rules demand.
  task automatic drive(input stim_t s);
    bit   rn_e, rn_m, rm_e, rm_m, hz, stall, done;
    bit   s_rne, s_rnm, s_rme, s_rmm;
    int   next_age;
    exp_t e;
    @(posedge clk);
    #1;
    rst = s.rst; Rn = s.rn; Rm = s.rm; use_Rn = s.use_rn; two_src = s.two_src;
    fwd_en = s.fwd_en; EXE_Dest = s.exe_dest; EXE_WB_EN = s.exe_wb;
    EXE_MEM_R_EN = s.exe_ld; MEM_Dest = s.mem_dest; MEM_WB_EN = s.mem_wb;
    B_taken = s.b_taken; mem_req = s.mem_req;

    rn_e = s.use_rn  && s.exe_wb && (s.exe_dest == s.rn);
    rn_m = s.use_rn  && s.mem_wb && (s.mem_dest == s.rn);
    rm_e = s.two_src && s.exe_wb && (s.exe_dest == s.rm);
    rm_m = s.two_src && s.mem_wb && (s.mem_dest == s.rm);
    if (s.fwd_en) hz = s.exe_ld && (rn_e || rm_e);
    else          hz = rn_e || rn_m || rm_e || rm_m;
    s_rne = s.fwd_en && !hz && rn_e && !s.exe_ld;
    s_rnm = s.fwd_en && !hz && rn_m && !rn_e;
    s_rme = s.fwd_en && !hz && rm_e && !s.exe_ld;
    s_rmm = s.fwd_en && !hz && rm_m && !rm_e;

    // An access stalls for SRAM_WAIT cycles and completes on the next one.
    if (acc_age == 0) begin
      stall    = s.mem_req && (SRAM_WAIT > 0);
      done     = s.mem_req && (SRAM_WAIT == 0);
      next_age = stall ? 1 : 0;
    end else begin
      stall    = acc_age < int'(SRAM_WAIT);
      done     = acc_age == int'(SRAM_WAIT);
      next_age = done ? 0 : acc_age + 1;
    end

    if (s.rst) begin
      e.v      = '0;
      next_age = 0;
    end else begin
      e.v = {stall || hz, stall, !stall && s.b_taken, !stall && (hz || s.b_taken),
             s_rne, s_rnm, s_rme, s_rmm, done};
    end
    e.cyc   = cyc;
    acc_age = next_age;
    cyc++;
    exp_q.push_back(e);
  endtask

  // Monitor: compare each presented cycle against the queued expectation.
  initial begin
    exp_t       e;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {freeze_front, freeze_back, flush_ifid, flush_idex,
               fRnSEXE, fRnSMEM, fRmSEXE, fRmSMEM, mem_done};
        for (int i = 0; i < 9; i++) begin
          n_checks++;
          if (act[i] !== e.v[i]) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0b expected %0b",
                     names[i], e.cyc, act[i], e.v[i]);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    rst = 1'b1; Rn = '0; Rm = '0; use_Rn = 1'b0; two_src = 1'b0; fwd_en = 1'b0;
    EXE_Dest = '0; EXE_WB_EN = 1'b0; EXE_MEM_R_EN = 1'b0; MEM_Dest = '0;
    MEM_WB_EN = 1'b0; B_taken = 1'b0; mem_req = 1'b0;

    s = idle_stim(); s.rst = 1'b1; s.mem_req = 1'b1; s.b_taken = 1'b1;
    repeat (2) drive(s);

    // SRAM access held from its first cycle
    s = idle_stim(); s.mem_req = 1'b1;
    repeat (4) drive(s);
    s.mem_req = 1'b0; drive(s);

    // load-use hazard
    s = idle_stim(); s.exe_ld = 1'b1; s.exe_wb = 1'b1; s.exe_dest = 4'd4;
    s.rn = 4'd4; s.use_rn = 1'b1;
    drive(s);

    // EXE beats MEM for Rm, then MEM alone
    s = idle_stim(); s.exe_dest = 4'd2; s.mem_dest = 4'd2; s.exe_wb = 1'b1;
    s.mem_wb = 1'b1; s.rm = 4'd2; s.two_src = 1'b1;
    drive(s);
    s.exe_wb = 1'b0; drive(s);

    // stall-only mode with a MEM-stage writer
    s = idle_stim(); s.fwd_en = 1'b0; s.mem_dest = 4'd7; s.mem_wb = 1'b1;
    s.rn = 4'd7; s.use_rn = 1'b1;
    drive(s);

    // branch during a stall, held until the DONE cycle
    s = idle_stim(); s.mem_req = 1'b1;
    drive(s);
    s.b_taken = 1'b1; repeat (3) drive(s);
    s.mem_req = 1'b0; drive(s);
    s = idle_stim(); drive(s);

    // hazard and branch together
    s = idle_stim(); s.exe_ld = 1'b1; s.exe_wb = 1'b1; s.exe_dest = 4'd9;
    s.rm = 4'd9; s.two_src = 1'b1; s.b_taken = 1'b1;
    drive(s);

    // reset in the second WAIT cycle, then a fresh access
    s = idle_stim(); s.mem_req = 1'b1;
    repeat (2) drive(s);
    s.rst = 1'b1; drive(s);
    s = idle_stim(); drive(s);
    s.mem_req = 1'b1; repeat (4) drive(s);
    s = idle_stim(); drive(s);

    for (int n = 0; n < 3000; n++) begin
      s.rst      = ($urandom_range(63) == 0);
      s.rn       = 4'($urandom_range(3));
      s.rm       = 4'($urandom_range(3));
      s.exe_dest = 4'($urandom_range(3));
      s.mem_dest = 4'($urandom_range(3));
      s.use_rn   = 1'($urandom_range(1));
      s.two_src  = 1'($urandom_range(1));
      s.fwd_en   = ($urandom_range(3) != 0);
      s.exe_wb   = 1'($urandom_range(1));
      s.exe_ld   = ($urandom_range(3) == 0);
      s.mem_wb   = 1'($urandom_range(1));
      s.b_taken  = ($urandom_range(3) == 0);
      s.mem_req  = ($urandom_range(3) == 0);
      drive(s);
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
